// File: rtl/alt_sched.sv
// Altitude command scheduler: fixed-priority owner arbitration plus a dwell-paced
// one-level-per-step slew of the registered altitude command toward the owner's target.
module alt_sched #(
  parameter logic [15:0] DWELL    = 16'd100,
  parameter logic [15:0] DWELL_FS = 16'd10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [2:0] cmd_fs,
  input  logic [2:0] cmd_ap,
  input  logic [2:0] cmd_pl,
  output logic [2:0] gnt,
  output logic [2:0] altcmd,
  output logic       busy
);

  typedef enum logic {
    S_HOLD,
    S_DWELL
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         gnt_q, gnt_d;
  logic signed [2:0]  cur_q, cur_d;
  logic [2:0]         altcmd_q;
  logic               busy_q;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [2:0]  target;
  logic signed [2:0]  step_lvl;
  logic [15:0]        dwell_m1;

  function automatic logic signed [2:0] decode(input logic [2:0] c);
    logic signed [2:0] m;
    m = signed'({1'b0, c[1:0]});
    return c[2] ? -m : m;
  endfunction

  // Level zero always encodes as 000, never as the negative-zero 100.
  function automatic logic [2:0] encode(input logic signed [2:0] l);
    logic signed [2:0] n;
    n = -l;
    if (l < 0) return {1'b1, n[1:0]};
    else       return {1'b0, l[1:0]};
  endfunction

  always_comb begin
    gnt_d = 3'b000;
    if      (req[0]) gnt_d = 3'b001;
    else if (req[1]) gnt_d = 3'b010;
    else if (req[2]) gnt_d = 3'b100;
  end

  always_comb begin
    target = 3'sd0;
    case (gnt_q)
      3'b001:  target = decode(cmd_fs);
      3'b010:  target = decode(cmd_ap);
      3'b100:  target = decode(cmd_pl);
      default: target = 3'sd0;
    endcase
  end

  // Dwell length follows whoever owns the channel when the counter is (re)loaded.
  assign dwell_m1 = (gnt_q == 3'b001) ? (DWELL_FS - 16'd1) : (DWELL - 16'd1);
  assign step_lvl = (target > cur_q) ? (cur_q + 3'sd1) : (cur_q - 3'sd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    case (state_q)
      S_HOLD: begin
        if (target != cur_q) begin
          cnt_d   = dwell_m1;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
          if (target == cur_q) state_d = S_HOLD;
        end else if (target != cur_q) begin
          cur_d = step_lvl;
          if (step_lvl == target) state_d = S_HOLD;
          else                    cnt_d   = dwell_m1;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_HOLD;
      gnt_q    <= 3'b000;
      cur_q    <= 3'sd0;
      altcmd_q <= 3'b000;
      busy_q   <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cur_q    <= cur_d;
      altcmd_q <= encode(cur_d);
      busy_q   <= (state_d == S_DWELL);
      cnt_q    <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign altcmd = altcmd_q;
  assign busy   = busy_q;

endmodule
